writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit_if.sv | 47 ++++
 rtl/writeback_unit.sv | 143 ++++++++++++++
 tb/tb_writeback_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_unit_if.sv
// Writeback unit bus: ALU/LSU result offers, issue marks,
// operand busy/forward queries and the register-file write port.
interface writeback_unit_if;
  logic        iALU_VALID;
  logic [4:0]  iALU_RD;
  logic [31:0] iALU_DATA;
  logic        oALU_READY;
  logic        iLSU_VALID;
  logic [4:0]  iLSU_RD;
  logic [31:0] iLSU_DATA;
  logic        oLSU_READY;
  logic        iISSUE_VALID;
  logic [4:0]  iISSUE_RD;
  logic [4:0]  iRS1;
  logic [4:0]  iRS2;
  logic        oRS1_BUSY;
  logic        oRS2_BUSY;
  logic [31:0] oRS1_FWD;
  logic [31:0] oRS2_FWD;
  logic        oWB_VALID;
  logic [4:0]  oRD;
  logic [31:0] oWB_DATA;

  modport master (
    output iALU_VALID, iALU_RD, iALU_DATA,
    input  oALU_READY,
    output iLSU_VALID, iLSU_RD, iLSU_DATA,
    input  oLSU_READY,
    output iISSUE_VALID, iISSUE_RD,
    output iRS1, iRS2,
    input  oRS1_BUSY, oRS2_BUSY,
    input  oRS1_FWD, oRS2_FWD,
    input  oWB_VALID, oRD, oWB_DATA
  );

  modport slave (
    input  iALU_VALID, iALU_RD, iALU_DATA,
    output oALU_READY,
    input  iLSU_VALID, iLSU_RD, iLSU_DATA,
    output oLSU_READY,
    input  iISSUE_VALID, iISSUE_RD,
    input  iRS1, iRS2,
    output oRS1_BUSY, oRS2_BUSY,
    output oRS1_FWD, oRS2_FWD,
    output oWB_VALID, oRD, oWB_DATA
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback arbiter: ALU vs buffered LSU results, plus a register scoreboard.
// Define WB_FORWARD_EN to forward the committing value to operand queries.
module writeback_unit #(
  parameter int FIFO_DEPTH = 4
) (
  input logic iCLK,
  input logic iRST,
  writeback_unit_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [4:0]    r_fifo_rd   [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_sb;
  logic          r_wb_valid;
  logic [4:0]    r_rd;
  logic [31:0]   r_wb_data;

  logic          w_full;
  logic          w_empty;
  logic          w_alu_acc;
  logic          w_pop;
  logic          w_push;
  logic          w_lsu_ready;
  logic          w_win_valid;
  logic [4:0]    w_win_rd;
  logic [31:0]   w_win_data;
  logic [31:0]   w_sb_next;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // ALU has the port unless the LSU buffer is full; the head drains
  // whenever the ALU is not taking the port, so a full buffer always pops.
  assign w_alu_acc   = bus.iALU_VALID & ~w_full;
  assign w_pop       = ~w_empty & (w_full | ~bus.iALU_VALID);
  assign w_lsu_ready = ~w_full | w_pop;
  assign w_push      = bus.iLSU_VALID & w_lsu_ready;

  assign bus.oALU_READY = ~w_full;
  assign bus.oLSU_READY = w_lsu_ready;

  // Select the winning result; rd=0 writes are consumed with zero data.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_rd    = '0;
    w_win_data  = '0;
    unique case (1'b1)
      w_alu_acc: begin
        w_win_valid = 1'b1;
        w_win_rd    = bus.iALU_RD;
        w_win_data  = (bus.iALU_RD == '0) ? '0 : bus.iALU_DATA;
      end
      w_pop: begin
        w_win_valid = 1'b1;
        w_win_rd    = r_fifo_rd[r_rptr];
        w_win_data  = (r_fifo_rd[r_rptr] == '0) ? '0
                                                : r_fifo_data[r_rptr];
      end
      default: begin
        w_win_valid = 1'b0;
      end
    endcase
  end

  // Store accepted LSU results at the write pointer.
  always_ff @(posedge iCLK) begin
    if (!iRST && w_push) begin
      r_fifo_rd[r_wptr]   <= bus.iLSU_RD;
      r_fifo_data[r_wptr] <= bus.iLSU_DATA;
    end
  end

  // Buffer pointers and occupancy; pop and push may coincide when full.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Register the write port; idle cycles present all zeros.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_wb_valid <= 1'b0;
      r_rd       <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= w_win_valid;
      r_rd       <= w_win_rd;
      r_wb_data  <= w_win_data;
    end
  end

  assign bus.oWB_VALID = r_wb_valid;
  assign bus.oRD       = r_rd;
  assign bus.oWB_DATA  = r_wb_data;

  // Clear on commit first, then set on issue so a new issue wins.
  always_comb begin
    w_sb_next = r_sb;
    if (r_wb_valid) w_sb_next[r_rd] = 1'b0;
    if (bus.iISSUE_VALID) w_sb_next[bus.iISSUE_RD] = 1'b1;
    w_sb_next[0] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge iCLK) begin
    if (iRST) r_sb <= '0;
    else      r_sb <= w_sb_next;
  end

`ifdef WB_FORWARD_EN
  logic w_hit1;
  logic w_hit2;

  assign w_hit1 = r_wb_valid & (r_rd == bus.iRS1) & (bus.iRS1 != '0);
  assign w_hit2 = r_wb_valid & (r_rd == bus.iRS2) & (bus.iRS2 != '0);

  assign bus.oRS1_BUSY = r_sb[bus.iRS1] & ~w_hit1;
  assign bus.oRS2_BUSY = r_sb[bus.iRS2] & ~w_hit2;
  assign bus.oRS1_FWD  = w_hit1 ? r_wb_data : '0;
  assign bus.oRS2_FWD  = w_hit2 ? r_wb_data : '0;
`else
  assign bus.oRS1_BUSY = r_sb[bus.iRS1];
  assign bus.oRS2_BUSY = r_sb[bus.iRS2];
  assign bus.oRS1_FWD  = '0;
  assign bus.oRS2_FWD  = '0;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: arbitration, LSU buffer,
// scoreboard, rd=0 handling, forwarding and reset.
module tb_writeback_unit;
  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  writeback_unit_if bus();

  writeback_unit #(.FIFO_DEPTH(4)) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus(bus)
  );

  always #5 iCLK = ~iCLK;

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle();
    bus.iALU_VALID   = 1'b0;
    bus.iALU_RD      = '0;
    bus.iALU_DATA    = '0;
    bus.iLSU_VALID   = 1'b0;
    bus.iLSU_RD      = '0;
    bus.iLSU_DATA    = '0;
    bus.iISSUE_VALID = 1'b0;
    bus.iISSUE_RD    = '0;
  endtask

  task automatic test_reset();
    idle();
    bus.iRS1 = 5'd2;
    bus.iRS2 = 5'd0;
    iRST = 1'b1;
    bus.iALU_VALID   = 1'b1;
    bus.iALU_RD      = 5'd2;
    bus.iALU_DATA    = 32'h5;
    bus.iLSU_VALID   = 1'b1;
    bus.iLSU_RD      = 5'd3;
    bus.iLSU_DATA    = 32'h6;
    bus.iISSUE_VALID = 1'b1;
    bus.iISSUE_RD    = 5'd2;
    step();
    step();
    n_checks++;
    if (bus.oWB_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got %b exp 0", bus.oWB_VALID);
    end
    n_checks++;
    if (bus.oRD !== 5'd0 || bus.oWB_DATA !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_out got rd=%0d data=%h exp 0/0",
               bus.oRD, bus.oWB_DATA);
    end
    n_checks++;
    if (bus.oALU_READY !== 1'b1 || bus.oLSU_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready got %b%b exp 11",
               bus.oALU_READY, bus.oLSU_READY);
    end
    iRST = 1'b0;
    idle();
    step();
    n_checks++;
    if (bus.oWB_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ignore_offer got %b exp 0", bus.oWB_VALID);
    end
    n_checks++;
    if (bus.oRS1_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ignore_issue got %b exp 0", bus.oRS1_BUSY);
    end
  endtask

  task automatic test_issue_commit();
    idle();
    bus.iRS1 = 5'd5;
    bus.iISSUE_VALID = 1'b1;
    bus.iISSUE_RD    = 5'd5;
    step();
    bus.iISSUE_VALID = 1'b0;
    n_checks++;
    if (bus.oRS1_BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_busy got %b exp 1", bus.oRS1_BUSY);
    end
    bus.iALU_VALID = 1'b1;
    bus.iALU_RD    = 5'd5;
    bus.iALU_DATA  = 32'h1234;
    #1;
    n_checks++;
    if (bus.oALU_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_ready got %b exp 1", bus.oALU_READY);
    end
    step();
    idle();
    n_checks++;
    if (bus.oWB_VALID !== 1'b1 || bus.oRD !== 5'd5 ||
        bus.oWB_DATA !== 32'h1234) begin
      n_fail++;
      $display("FAIL commit got v=%b rd=%0d d=%h exp 1/5/1234",
               bus.oWB_VALID, bus.oRD, bus.oWB_DATA);
    end
    step();
    n_checks++;
    if (bus.oRS1_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_clear got %b exp 0", bus.oRS1_BUSY);
    end
    n_checks++;
    if (bus.oWB_VALID !== 1'b0 || bus.oRD !== 5'd0 ||
        bus.oWB_DATA !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_out got v=%b rd=%0d d=%h exp 0/0/0",
               bus.oWB_VALID, bus.oRD, bus.oWB_DATA);
    end
  endtask

  task automatic test_dual();
    idle();
    bus.iALU_VALID = 1'b1;
    bus.iALU_RD    = 5'd3;
    bus.iALU_DATA  = 32'hA;
    bus.iLSU_VALID = 1'b1;
    bus.iLSU_RD    = 5'd4;
    bus.iLSU_DATA  = 32'hB;
    step();
    idle();
    n_checks++;
    if (bus.oWB_VALID !== 1'b1 || bus.oRD !== 5'd3 ||
        bus.oWB_DATA !== 32'hA) begin
      n_fail++;
      $display("FAIL dual_alu got v=%b rd=%0d d=%h exp 1/3/A",
               bus.oWB_VALID, bus.oRD, bus.oWB_DATA);
    end
    step();
    n_checks++;
    if (bus.oWB_VALID !== 1'b1 || bus.oRD !== 5'd4 ||
        bus.oWB_DATA !== 32'hB) begin
      n_fail++;
      $display("FAIL dual_lsu got v=%b rd=%0d d=%h exp 1/4/B",
               bus.oWB_VALID, bus.oRD, bus.oWB_DATA);
    end
    step();
    n_checks++;
    if (bus.oWB_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL dual_drain got %b exp 0", bus.oWB_VALID);
    end
  endtask

  task automatic test_fill_wrap();
    logic [4:0]  exp_rd [3];
    logic [31:0] exp_d  [3];
    idle();
    bus.iALU_VALID = 1'b1;
    bus.iALU_RD    = 5'd1;
    bus.iALU_DATA  = 32'h11;
    for (int k = 0; k < 4; k++) begin
      bus.iLSU_VALID = 1'b1;
      bus.iLSU_RD    = 5'(10 + k);
      bus.iLSU_DATA  = 32'hB0 + 32'(k);
      step();
      n_checks++;
      if (bus.oRD !== 5'd1 || bus.oWB_DATA !== 32'h11) begin
        n_fail++;
        $display("FAIL fill_alu%0d got rd=%0d d=%h exp 1/11",
                 k, bus.oRD, bus.oWB_DATA);
      end
    end
    n_checks++;
    if (bus.oALU_READY !== 1'b0 || bus.oLSU_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ready got %b%b exp 01",
               bus.oALU_READY, bus.oLSU_READY);
    end
    bus.iLSU_RD   = 5'd14;
    bus.iLSU_DATA = 32'hB4;
    step();
    bus.iLSU_VALID = 1'b0;
    n_checks++;
    if (bus.oWB_VALID !== 1'b1 || bus.oRD !== 5'd10 ||
        bus.oWB_DATA !== 32'hB0) begin
      n_fail++;
      $display("FAIL full_pop0 got v=%b rd=%0d d=%h exp 1/10/B0",
               bus.oWB_VALID, bus.oRD, bus.oWB_DATA);
    end
    n_checks++;
    if (bus.oALU_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL still_full got %b exp 0", bus.oALU_READY);
    end
    step();
    n_checks++;
    if (bus.oRD !== 5'd11 || bus.oWB_DATA !== 32'hB1) begin
      n_fail++;
      $display("FAIL full_pop1 got rd=%0d d=%h exp 11/B1",
               bus.oRD, bus.oWB_DATA);
    end
    n_checks++;
    if (bus.oALU_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL unfull_ready got %b exp 1", bus.oALU_READY);
    end
    step();
    bus.iALU_VALID = 1'b0;
    n_checks++;
    if (bus.oRD !== 5'd1 || bus.oWB_DATA !== 32'h11) begin
      n_fail++;
      $display("FAIL alu_resume got rd=%0d d=%h exp 1/11",
               bus.oRD, bus.oWB_DATA);
    end
    exp_rd = '{5'd12, 5'd13, 5'd14};
    exp_d  = '{32'hB2, 32'hB3, 32'hB4};
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (bus.oWB_VALID !== 1'b1 || bus.oRD !== exp_rd[k] ||
          bus.oWB_DATA !== exp_d[k]) begin
        n_fail++;
        $display("FAIL drain%0d got v=%b rd=%0d d=%h exp 1/%0d/%h",
                 k, bus.oWB_VALID, bus.oRD, bus.oWB_DATA,
                 exp_rd[k], exp_d[k]);
      end
    end
    step();
    n_checks++;
    if (bus.oWB_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty got %b exp 0", bus.oWB_VALID);
    end
  endtask

  task automatic test_rd_zero();
    idle();
    bus.iRS1 = 5'd0;
    bus.iALU_VALID   = 1'b1;
    bus.iALU_RD      = 5'd0;
    bus.iALU_DATA    = 32'hFFFF;
    bus.iISSUE_VALID = 1'b1;
    bus.iISSUE_RD    = 5'd0;
    step();
    idle();
    n_checks++;
    if (bus.oWB_VALID !== 1'b1 || bus.oRD !== 5'd0 ||
        bus.oWB_DATA !== 32'h0) begin
      n_fail++;
      $display("FAIL rd0 got v=%b rd=%0d d=%h exp 1/0/0",
               bus.oWB_VALID, bus.oRD, bus.oWB_DATA);
    end
    n_checks++;
    if (bus.oRS1_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL rd0_busy got %b exp 0", bus.oRS1_BUSY);
    end
    step();
  endtask

  task automatic test_set_clear();
    idle();
    bus.iRS1 = 5'd7;
    bus.iISSUE_VALID = 1'b1;
    bus.iISSUE_RD    = 5'd7;
    step();
    idle();
    bus.iALU_VALID = 1'b1;
    bus.iALU_RD    = 5'd7;
    bus.iALU_DATA  = 32'h77;
    step();
    idle();
    n_checks++;
    if (bus.oWB_VALID !== 1'b1 || bus.oRD !== 5'd7) begin
      n_fail++;
      $display("FAIL sc_commit got v=%b rd=%0d exp 1/7",
               bus.oWB_VALID, bus.oRD);
    end
    bus.iISSUE_VALID = 1'b1;
    bus.iISSUE_RD    = 5'd7;
    step();
    idle();
    n_checks++;
    if (bus.oRS1_BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins got %b exp 1", bus.oRS1_BUSY);
    end
    bus.iALU_VALID = 1'b1;
    bus.iALU_RD    = 5'd7;
    bus.iALU_DATA  = 32'h78;
    step();
    idle();
    step();
    n_checks++;
    if (bus.oRS1_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reclear got %b exp 0", bus.oRS1_BUSY);
    end
  endtask

  task automatic test_forward_reset();
    idle();
    bus.iRS2 = 5'd9;
    bus.iISSUE_VALID = 1'b1;
    bus.iISSUE_RD    = 5'd9;
    step();
    idle();
    bus.iALU_VALID = 1'b1;
    bus.iALU_RD    = 5'd9;
    bus.iALU_DATA  = 32'hDEAD;
    step();
    idle();
`ifdef WB_FORWARD_EN
    n_checks++;
    if (bus.oRS2_BUSY !== 1'b0 || bus.oRS2_FWD !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL fwd got b=%b f=%h exp 0/DEAD",
               bus.oRS2_BUSY, bus.oRS2_FWD);
    end
`else
    n_checks++;
    if (bus.oRS2_BUSY !== 1'b1 || bus.oRS2_FWD !== 32'h0) begin
      n_fail++;
      $display("FAIL nofwd got b=%b f=%h exp 1/0",
               bus.oRS2_BUSY, bus.oRS2_FWD);
    end
`endif
    step();
    bus.iRS1 = 5'd12;
    bus.iALU_VALID   = 1'b1;
    bus.iALU_RD      = 5'd1;
    bus.iALU_DATA    = 32'h1;
    bus.iISSUE_VALID = 1'b1;
    bus.iISSUE_RD    = 5'd12;
    for (int k = 0; k < 2; k++) begin
      bus.iLSU_VALID = 1'b1;
      bus.iLSU_RD    = 5'(20 + k);
      bus.iLSU_DATA  = 32'hC0 + 32'(k);
      step();
    end
    idle();
    n_checks++;
    if (bus.oRS1_BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst_busy got %b exp 1", bus.oRS1_BUSY);
    end
    iRST = 1'b1;
    step();
    n_checks++;
    if (bus.oWB_VALID !== 1'b0 || bus.oRD !== 5'd0 ||
        bus.oWB_DATA !== 32'h0 || bus.oRS1_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst got v=%b rd=%0d d=%h b=%b exp 0/0/0/0",
               bus.oWB_VALID, bus.oRD, bus.oWB_DATA, bus.oRS1_BUSY);
    end
    iRST = 1'b0;
    step();
    n_checks++;
    if (bus.oWB_VALID !== 1'b0 || bus.oALU_READY !== 1'b1 ||
        bus.oLSU_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst got v=%b r=%b%b exp 0/11",
               bus.oWB_VALID, bus.oALU_READY, bus.oLSU_READY);
    end
  endtask

  initial begin
    test_reset();
    test_issue_commit();
    test_dual();
    test_fill_wrap();
    test_rd_zero();
    test_set_clear();
    test_forward_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
